// File: rtl/dummy_adc_pkg.sv
// dummy_adc_pkg
// Shared constants and types for the dummy analog front end:
//   - NUM_CH / CH_LEVEL : per-channel sigma-delta levels driven by the amux
//   - LOCK_CYCLES       : PLL enable cycles before the model reports lock
//   - STAT_*            : bit positions inside the STATUS word
//   - adc_state_e       : conversion FSM state
//   - osr_last()        : last index of the oversampling window for OSR k
package dummy_adc_pkg;

  localparam int NUM_CH      = 8;
  localparam int LOCK_CYCLES = 4;

  // Fixed "analog" level per channel; the stream density is level/256.
  localparam logic [7:0] CH_LEVEL [NUM_CH] = '{
    8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'h20, 8'hA0, 8'h10
  };

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_LOCKED  = 2;
  localparam int STAT_CH_LSB  = 4;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic {
    ADC_IDLE = 1'b0,
    ADC_CONV = 1'b1
  } adc_state_e;

  // Window length is 256 << k; the FSM counts down to zero, so load N-1.
  // k=7 gives 32768, which still fits in 16 bits.
  function automatic logic [15:0] osr_last(input logic [2:0] k);
    return (16'd256 << k) - 16'd1;
  endfunction

endpackage

// File: rtl/dummy_adc.sv
// dummy_adc
// PLL lock model, trigger edge detection and the oversampling counter.
// Ports:
//   PCLK, PRESETn   : clock, async active-low reset
//   i_pll_en        : PLL enable (PLL_CONTROL[0])
//   i_osr_k         : OSR select, window = 256 << k cycles
//   i_trigger       : conversion request, rising edge sensitive
//   i_chan          : channel number recorded in STATUS at start
//   i_analog        : 1-bit stream from the amux
//   o_status        : {conv_cnt, 1'b0, chan, 1'b0, locked, done, busy}
//   o_measurement   : last completed count
module dummy_adc
  import dummy_adc_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        i_pll_en,
  input  logic [2:0]  i_osr_k,
  input  logic        i_trigger,
  input  logic [2:0]  i_chan,
  input  logic        i_analog,
  output logic [15:0] o_status,
  output logic [15:0] o_measurement
);

  adc_state_e  r_state;
  logic [2:0]  r_lock_cnt;
  logic        r_locked;
  logic        r_trig_prev;
  logic        r_done;
  logic [2:0]  r_chan;
  logic [15:0] r_remain;
  logic [15:0] r_count;
  logic [15:0] r_meas;
  logic [7:0]  r_conv_cnt;

  logic [2:0]  w_lock_cnt_nxt;
  logic        w_start;
  logic [15:0] w_status;

  // Lock counter: count up while enabled, saturate at LOCK_CYCLES, clear when off.
  always_comb begin
    w_lock_cnt_nxt = 3'd0;
    if (i_pll_en) begin
      if (r_lock_cnt == 3'(LOCK_CYCLES)) begin
        w_lock_cnt_nxt = r_lock_cnt;
      end else begin
        w_lock_cnt_nxt = r_lock_cnt + 3'd1;
      end
    end else begin
      w_lock_cnt_nxt = 3'd0;
    end
  end

  // Lock state and trigger history.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_lock_cnt  <= 3'd0;
      r_locked    <= 1'b0;
      r_trig_prev <= 1'b0;
    end else begin
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_locked    <= (w_lock_cnt_nxt == 3'(LOCK_CYCLES));
      r_trig_prev <= i_trigger;
    end
  end

  // Edges arriving while busy or unlocked are dropped, not queued.
  assign w_start = i_trigger & ~r_trig_prev & r_locked & (r_state == ADC_IDLE);

  // Conversion FSM.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= ADC_IDLE;
      r_done     <= 1'b0;
      r_chan     <= 3'd0;
      r_remain   <= 16'd0;
      r_count    <= 16'd0;
      r_meas     <= 16'd0;
      r_conv_cnt <= 8'd0;
    end else begin
      case (r_state)
        ADC_IDLE: begin
          if (w_start) begin
            r_state  <= ADC_CONV;
            r_done   <= 1'b0;
            r_chan   <= i_chan;
            r_count  <= 16'd0;
            r_remain <= osr_last(i_osr_k);
          end
        end
        ADC_CONV: begin
          if (!r_locked) begin
            // Lost lock: drop the window, keep the previous result.
            r_state <= ADC_IDLE;
            r_done  <= 1'b0;
          end else if (r_remain == 16'd0) begin
            // Last sample is folded straight into the published result.
            r_state    <= ADC_IDLE;
            r_done     <= 1'b1;
            r_meas     <= r_count + {15'd0, i_analog};
            r_conv_cnt <= r_conv_cnt + 8'd1;
          end else begin
            r_remain <= r_remain - 16'd1;
            r_count  <= r_count + {15'd0, i_analog};
          end
        end
        default: begin
          r_state <= ADC_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Status word assembled from registers only.
  always_comb begin
    w_status                        = 16'd0;
    w_status[STAT_BUSY]             = (r_state == ADC_CONV);
    w_status[STAT_DONE]             = r_done;
    w_status[STAT_LOCKED]           = r_locked;
    w_status[STAT_CH_LSB +: 3]      = r_chan;
    w_status[STAT_CNT_LSB +: 8]     = r_conv_cnt;
  end

  assign o_status      = w_status;
  assign o_measurement = r_meas;

endmodule

// File: rtl/dummy_adc_amux.sv
// dummy_amux
// Eight free-running 8-bit phase accumulators, one per channel. Each adds its
// fixed level every cycle; the carry-out is that channel's 1-bit stream.
// Ports:
//   PCLK, PRESETn : clock, async active-low reset
//   i_input_sel   : channel select, values above 7 give a constant 0 stream
//   o_analog      : registered stream bit of the selected channel
module dummy_amux
  import dummy_adc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [DATA_WIDTH-1:0] i_input_sel,
  output logic                  o_analog
);

  logic [NUM_CH-1:0] w_carry;
  logic              w_sel_valid;
  logic              r_analog;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [7:0] r_acc;
    logic [8:0] w_sum;

    assign w_sum      = {1'b0, r_acc} + {1'b0, CH_LEVEL[g]};
    assign w_carry[g] = w_sum[8];

    // Accumulators run whether or not the channel is selected.
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        r_acc <= 8'd0;
      end else begin
        r_acc <= w_sum[7:0];
      end
    end
  end

  assign w_sel_valid = (i_input_sel[DATA_WIDTH-1:3] == '0);

  // Register the selected carry; this is the one-cycle select latency.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_analog <= 1'b0;
    end else if (w_sel_valid) begin
      r_analog <= w_carry[i_input_sel[2:0]];
    end else begin
      r_analog <= 1'b0;
    end
  end

  assign o_analog = r_analog;

endmodule

// File: rtl/dummy_adc_frontend.sv
// dummy_adc_frontend
// Behavioural analog front end behind the ADC APB wrapper: amux stream
// generator feeding the oversampling ADC model.
// Ports:
//   PCLK, PRESETn : clock, async active-low reset
//   PLL_CONTROL   : [0] PLL enable, [3:1] OSR select k
//   ADC_TRIGGER   : [0] rising edge starts a conversion
//   INPUT_SEL     : amux channel, 0..7 valid
//   STATUS        : [0] busy [1] done [2] locked [6:4] chan [15:8] conv_cnt
//   MEASUREMENT   : [15:0] last result, upper bits zero
module dummy_adc_frontend
  import dummy_adc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [DATA_WIDTH-1:0] PLL_CONTROL,
  input  logic [DATA_WIDTH-1:0] ADC_TRIGGER,
  input  logic [DATA_WIDTH-1:0] INPUT_SEL,
  output logic [DATA_WIDTH-1:0] STATUS,
  output logic [DATA_WIDTH-1:0] MEASUREMENT
);

  logic        w_analog_passthrough;
  logic [15:0] w_status;
  logic [15:0] w_measurement;
  logic        w_unused_ctrl;

  // Register bits the model does not interpret.
  assign w_unused_ctrl = ^{PLL_CONTROL[DATA_WIDTH-1:4], ADC_TRIGGER[DATA_WIDTH-1:1]};

  dummy_amux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_amux (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .i_input_sel (INPUT_SEL),
    .o_analog    (w_analog_passthrough)
  );

  dummy_adc u_adc (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .i_pll_en      (PLL_CONTROL[0]),
    .i_osr_k       (PLL_CONTROL[3:1]),
    .i_trigger     (ADC_TRIGGER[0]),
    .i_chan        (INPUT_SEL[2:0]),
    .i_analog      (w_analog_passthrough),
    .o_status      (w_status),
    .o_measurement (w_measurement)
  );

  assign STATUS      = {{(DATA_WIDTH-16){1'b0}}, w_status};
  assign MEASUREMENT = {{(DATA_WIDTH-16){1'b0}}, w_measurement};

endmodule

// File: tb/tb_dummy_adc_frontend.sv
module tb_dummy_adc_frontend;

  localparam int DW = 32;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic [DW-1:0] PLL_CONTROL = '0;
  logic [DW-1:0] ADC_TRIGGER = '0;
  logic [DW-1:0] INPUT_SEL = '0;
  logic [DW-1:0] STATUS;
  logic [DW-1:0] MEASUREMENT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  dummy_adc_frontend #(.DATA_WIDTH(DW)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .PLL_CONTROL (PLL_CONTROL),
    .ADC_TRIGGER (ADC_TRIGGER),
    .INPUT_SEL   (INPUT_SEL),
    .STATUS      (STATUS),
    .MEASUREMENT (MEASUREMENT)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view. A steady channel over a window of
  // 256<<k cycles yields exactly level<<k ones, so the result is computed
  // directly instead of simulating the stream.
  int lvl [8] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'h20, 8'hA0, 8'h10};
  int m_lock, m_left, m_expect, m_meas, m_cnt, m_chan;
  bit m_prev, m_busy, m_done;

  function automatic logic [DW-1:0] model_status();
    int v;
    v = int'(m_busy) + 2 * int'(m_done) + 4 * int'(m_lock == 4) + 16 * m_chan + 256 * m_cnt;
    return DW'(v);
  endfunction

  always begin
    @(posedge PCLK or negedge PRESETn);
    if (!PRESETn) begin
      m_lock = 0; m_left = 0; m_expect = 0; m_meas = 0; m_cnt = 0; m_chan = 0;
      m_prev = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      bit was_locked;
      bit rise;
      int k;
      was_locked = (m_lock == 4);
      rise       = ADC_TRIGGER[0] && !m_prev;
      m_prev     = ADC_TRIGGER[0];
      k          = int'(PLL_CONTROL[3:1]);
      if (PLL_CONTROL[0]) begin
        if (m_lock < 4) m_lock = m_lock + 1;
      end else begin
        m_lock = 0;
      end
      if (m_busy) begin
        if (!was_locked) begin
          m_busy = 1'b0;
          m_done = 1'b0;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_meas = m_expect;
            m_cnt  = (m_cnt + 1) % 256;
          end
        end
      end else if (rise && was_locked) begin
        m_busy   = 1'b1;
        m_done   = 1'b0;
        m_left   = 256 << k;
        m_chan   = int'(INPUT_SEL[2:0]);
        m_expect = (INPUT_SEL < 8) ? (lvl[INPUT_SEL[2:0]] << k) : 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(posedge PCLK) begin
    #1;
    check("status_vs_model", STATUS, model_status());
    check("meas_vs_model", MEASUREMENT, DW'(m_meas));
  end

  // Trigger pulse, then count cycles with busy high; optional retrigger.
  task automatic run_conv(input int retrig_at, output int cycles);
    ADC_TRIGGER = 32'd1;
    @(negedge PCLK);
    ADC_TRIGGER = 32'd0;
    cycles = 0;
    while (STATUS[0] === 1'b1 && cycles < 40000) begin
      cycles++;
      ADC_TRIGGER = (cycles == retrig_at) ? 32'd1 : 32'd0;
      @(negedge PCLK);
    end
    ADC_TRIGGER = 32'd0;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge PCLK);
    check("reset_status", STATUS, 32'h0);
    check("reset_meas", MEASUREMENT, 32'h0);
    PRESETn = 1'b1;

    // PLL off: trigger ignored
    ADC_TRIGGER = 32'd1; @(negedge PCLK); ADC_TRIGGER = 32'd0;
    repeat (5) @(negedge PCLK);
    check("nolock_status", STATUS, 32'h0);

    // PLL on, trigger sampled on 2nd enabled edge: ignored
    PLL_CONTROL = 32'h1; INPUT_SEL = 32'd2;
    @(negedge PCLK);
    ADC_TRIGGER = 32'd1; @(negedge PCLK); ADC_TRIGGER = 32'd0;
    repeat (3) @(negedge PCLK);
    check("early_trig_ignored", STATUS, 32'h4);

    // ch2, k=0
    run_conv(-1, n);
    check("ch2_busy_cycles", DW'(n), 32'd256);
    check("ch2_meas", MEASUREMENT, 32'h80);
    check("ch2_status", STATUS, 32'h126);

    // ch1, k=0 with a second trigger 10 cycles in
    do_reset();
    INPUT_SEL = 32'd1;
    repeat (6) @(negedge PCLK);
    run_conv(10, n);
    check("busytrig_cycles", DW'(n), 32'd256);
    check("busytrig_meas", MEASUREMENT, 32'h40);
    check("busytrig_status", STATUS, 32'h116);

    // ch4, k=1
    PLL_CONTROL = 32'h3; INPUT_SEL = 32'd4;
    repeat (3) @(negedge PCLK);
    run_conv(-1, n);
    check("ch4k1_busy_cycles", DW'(n), 32'd512);
    check("ch4k1_meas", MEASUREMENT, 32'h1FE);
    check("ch4k1_status", STATUS, 32'h246);

    // Abort by dropping PLL enable mid-conversion
    PLL_CONTROL = 32'h1; INPUT_SEL = 32'd1;
    repeat (2) @(negedge PCLK);
    ADC_TRIGGER = 32'd1; @(negedge PCLK); ADC_TRIGGER = 32'd0;
    repeat (50) @(negedge PCLK);
    PLL_CONTROL = 32'h0;
    repeat (3) @(negedge PCLK);
    check("abort_status", STATUS, 32'h210);
    check("abort_meas", MEASUREMENT, 32'h1FE);

    // Invalid channel gives zero
    PLL_CONTROL = 32'h1; INPUT_SEL = 32'd8;
    repeat (6) @(negedge PCLK);
    run_conv(-1, n);
    check("inv_busy_cycles", DW'(n), 32'd256);
    check("inv_meas", MEASUREMENT, 32'h0);
    check("inv_status", STATUS, 32'h306);

    // Reset mid-conversion
    INPUT_SEL = 32'd3;
    repeat (2) @(negedge PCLK);
    ADC_TRIGGER = 32'd1; @(negedge PCLK); ADC_TRIGGER = 32'd0;
    repeat (20) @(negedge PCLK);
    check("midconv_status", STATUS, 32'h335);
    PRESETn = 1'b0;
    #1;
    check("rst_mid_status", STATUS, 32'h0);
    check("rst_mid_meas", MEASUREMENT, 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (5) @(negedge PCLK);
    check("relock_after_reset", STATUS, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dummy_adc_frontend.md
# dummy_adc_frontend

Behavioural stand-in for the agriculture SoC analog front end, placed behind the ADC APB wrapper. It pairs a multiplexer model (`dummy_amux`) that emits a fixed per-channel 1-bit sigma-delta "analog" stream with an ADC model (`dummy_adc`). On trigger, the ADC model counts ones over an oversampling window and publishes a measurement and status word. All register values are driven by the wrapper's PLL, AMUX and trigger registers.

## Interface
- `DATA_WIDTH`, default 32: width of every control/status word.
- `PCLK` input 1: clock. All state is on the rising edge.
- `PRESETn` input 1: reset, asynchronous, active-low.
- `PLL_CONTROL` input DATA_WIDTH: bit0 is the PLL enable; bits[3:1] are OSR select k.
- `ADC_TRIGGER` input DATA_WIDTH: a rising edge of bit0 requests a conversion. Other bits are ignored.
- `INPUT_SEL` input DATA_WIDTH: channel select for the amux. Valid values are 0..7.
- `STATUS` output DATA_WIDTH: status word (layout below).
- `MEASUREMENT` output DATA_WIDTH: [15:0] holds the last result; [31:16] are always 0.

## Operation
- **amux:** 8 channels with fixed levels L = {0x00, 0x40, 0x80, 0xC0, 0xFF, 0x20, 0xA0, 0x10} for ch0..ch7.
  - Each channel has its own 8-bit accumulator. Every cycle: acc <= acc + L[n]. The stream bit for that channel is the carry-out.
  - All 8 accumulators run continuously, whether or not they are selected.
  - ANALOG_PASSTHROUGH is the registered carry of the selected channel.
  - If INPUT_SEL > 7, ANALOG_PASSTHROUGH is 0.
- **PLL lock:**
  - While PLL_CONTROL[0]=1, a 3-bit lock counter increments and saturates at 4. `locked` = (counter == 4).
  - When PLL_CONTROL[0]=0, the counter clears and `locked`=0 on the next edge.
- **Trigger:**
  - `trig_prev` registers ADC_TRIGGER[0].
  - A conversion starts when ADC_TRIGGER[0] & ~trig_prev & locked & ~busy.
  - An edge while busy, or while not locked, is discarded. It is not queued.
- **Conversion:**
  - busy=1 for exactly N = 256 << k cycles, with k latched at start.
  - Each busy cycle adds ANALOG_PASSTHROUGH to a 16-bit counter, which is cleared at start.
  - On the edge that ends the window: busy=0, done=1, MEASUREMENT[15:0] <= count, conv_cnt += 1 (8-bit, wraps).
- **Abort:**
  - If `locked` drops during a conversion, busy=0 and done=0 on the next edge.
  - MEASUREMENT and conv_cnt are left unchanged.
- **Channel change mid-conversion:** not blocked. The count mixes streams from both channels.
- **STATUS layout:**
  - [0] busy
  - [1] done. Sticky; cleared at next start or on abort.
  - [2] locked
  - [6:4] channel latched at start
  - [15:8] conv_cnt
  - All other bits 0.
- **Exact result:** for a steady valid channel, the result equals L × 2^k. Any 256 consecutive carries of an 8-bit accumulator contain exactly L ones, regardless of phase.

## Timing
- **Reset:** all accumulators, counters, `trig_prev`, STATUS and MEASUREMENT are 0, and ANALOG_PASSTHROUGH is 0.
  - Reset mid-conversion abandons the conversion completely.
- **Lock:** `locked` asserts on the 4th rising edge with PLL_CONTROL[0]=1.
- **Start:** trigger edge seen at edge T → busy=1 from edge T+1. Samples are taken at edges T+2 … T+1+N.
- **Completion:** MEASUREMENT and done update, and busy clears, at edge T+1+N.
- **Retrigger:** a trigger edge in the same cycle busy clears is discarded, because busy is still 1 when the edge is sampled.
- **Amux latency:** one PCLK cycle from INPUT_SEL change to the new channel's stream.

## Structure
- Package `dummy_adc_pkg` holds:
  - the channel-level constant array;
  - NUM_CH=8;
  - LOCK_CYCLES=4;
  - STATUS bit-position constants.
- Sub-module `dummy_amux`: INPUT_SEL → ANALOG_PASSTHROUGH. The conversion, lock and status logic live in `dummy_adc`.
- The top `dummy_adc_frontend` wires the two sub-modules together and also carries PCLK/PRESETn.

## Test plan
- **ch2, k=0:** PLL_CONTROL=0x1, INPUT_SEL=2, then pulse ADC_TRIGGER 0→1. Expect busy for 256 cycles, then MEASUREMENT=0x00000080, STATUS[1]=1, STATUS[15:8]=1, STATUS[6:4]=2.
- **ch4, k=1:** PLL_CONTROL=0x3, INPUT_SEL=4. Expect busy for 512 cycles, then MEASUREMENT=0x1FE.
- **Lock gating:**
  - PLL_CONTROL=0: trigger is ignored and STATUS stays 0.
  - PLL enabled, trigger in the 2nd cycle: ignored.
  - Trigger after 4 cycles: converts.
- **Busy trigger ignored:** a second trigger edge 10 cycles into a ch1 k=0 conversion → single result 0x40, conv_cnt=1, busy ends at cycle 256.
- **Abort:** clear PLL_CONTROL[0] mid-conversion → busy=0, done=0, MEASUREMENT keeps its old value, conv_cnt unchanged.
- **Invalid channel and reset:**
  - INPUT_SEL=8 → result 0.
  - Assert PRESETn low mid-conversion → all outputs 0 immediately.
